tdc_launch_seq: RTL and testbench



---
 rtl/tdc_launch_seq.sv | 218 +++++++++++++++++++++
 tb/tb_tdc_launch_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_launch_seq.sv
// -----------------------------------------------------------------------------
// tdc_launch_seq
//
// Launch sequencer that sits directly in front of the TDC pulse generator.
// A start request begins a burst of launches. Each launch toggles pg_tog and
// pulses pg_en for one cycle, so the pulse generator sends a fresh edge into
// the delay line. After each launch the block waits settle+1 cycles and
// strobes the capture stage in the last of those cycles. It then waits gap
// idle cycles before the next launch. The launch period is therefore
// 2+settle+gap cycles. A one-cycle done pulse follows the final strobe.
//
// Optional feature, selected at build time:
//   TDC_LSEQ_CONT_EN - num_launch==0 at start selects continuous mode.
//                      Launches repeat until abort or rst, and launch_cnt
//                      saturates. Without this macro, num_launch==0 produces
//                      an immediate done pulse and no launch.
//
// Ports:
//   clk_launch  in   launch clock (shared with the pulse generator)
//   rst         in   synchronous, active-high reset
//   start       in   one-cycle burst request; ignored unless idle
//   abort       in   ends the burst and returns to idle; has priority
//   num_launch  in   launches per burst; latched when start is accepted
//   settle      in   extra cycles between a launch and its capture strobe
//   gap         in   idle cycles after a strobe before the next launch
//   pg_en       out  one-cycle enable to the pulse generator per launch
//   pg_tog      out  toggle source; inverts once per launch
//   cap_strobe  out  one-cycle capture request to the sampler
//   busy        out  high from the first launch through the final strobe
//   done        out  one-cycle completion pulse
//   launch_cnt  out  strobes issued in the current or last burst
// -----------------------------------------------------------------------------
module tdc_launch_seq #(
   parameter int CNT_W = 8,
   parameter int TMR_W = 8
) (
   input  logic             clk_launch,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_launch,
   input  logic [TMR_W-1:0] settle,
   input  logic [TMR_W-1:0] gap,
   output logic             pg_en,
   output logic             pg_tog,
   output logic             cap_strobe,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] launch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_SETTLE,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] num_lat_q, num_lat_d;
   logic [TMR_W-1:0] settle_lat_q, settle_lat_d;
   logic [TMR_W-1:0] gap_lat_q, gap_lat_d;
   logic [CNT_W-1:0] launch_cnt_q, launch_cnt_d;
   logic             pg_en_q, pg_en_d;
   logic             pg_tog_q, pg_tog_d;
   logic             cap_strobe_q, cap_strobe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // One bit wider than the counter so that an all-ones count never
   // wraps to zero. Without that extra bit, a saturated continuous burst
   // (latched count of zero) would appear to have reached its end.
   logic [CNT_W:0]   cnt_plus1;
   assign cnt_plus1 = {1'b0, launch_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      num_lat_d    = num_lat_q;
      settle_lat_d = settle_lat_q;
      gap_lat_d    = gap_lat_q;
      launch_cnt_d = launch_cnt_q;
      pg_en_d      = 1'b0;
      pg_tog_d     = pg_tog_q;
      cap_strobe_d = 1'b0;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               num_lat_d    = num_launch;
               settle_lat_d = settle;
               gap_lat_d    = gap;
               launch_cnt_d = '0;
`ifdef TDC_LSEQ_CONT_EN
               state_d  = S_LAUNCH;
               pg_en_d  = 1'b1;
               pg_tog_d = ~pg_tog_q;
               busy_d   = 1'b1;
`else
               if (num_launch == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d  = S_LAUNCH;
                  pg_en_d  = 1'b1;
                  pg_tog_d = ~pg_tog_q;
                  busy_d   = 1'b1;
               end
`endif
            end
         end

         S_LAUNCH: begin
            // The timer holds the number of SETTLE cycles still to come
            // after the current one, so a settle of 0 strobes immediately.
            state_d      = S_SETTLE;
            timer_d      = settle_lat_q;
            cap_strobe_d = (settle_lat_q == '0);
         end

         S_SETTLE: begin
            if (timer_q != '0) begin
               timer_d      = timer_q - TMR_W'(1);
               cap_strobe_d = (timer_q == TMR_W'(1));
            end else begin
               // This is the strobe cycle.
               launch_cnt_d = (&launch_cnt_q) ? launch_cnt_q : cnt_plus1[CNT_W-1:0];
               if (cnt_plus1 == {1'b0, num_lat_q}) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else if (gap_lat_q == '0) begin
                  state_d  = S_LAUNCH;
                  pg_en_d  = 1'b1;
                  pg_tog_d = ~pg_tog_q;
               end else begin
                  state_d = S_GAP;
                  timer_d = gap_lat_q - TMR_W'(1);
               end
            end
         end

         S_GAP: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TMR_W'(1);
            end else begin
               state_d  = S_LAUNCH;
               pg_en_d  = 1'b1;
               pg_tog_d = ~pg_tog_q;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // abort overrides every transition above. pg_tog and launch_cnt
      // freeze, and no done pulse is produced.
      if (abort && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         timer_d      = '0;
         launch_cnt_d = launch_cnt_q;
         pg_en_d      = 1'b0;
         pg_tog_d     = pg_tog_q;
         cap_strobe_d = 1'b0;
         busy_d       = 1'b0;
         done_d       = 1'b0;
      end
   end

   always_ff @(posedge clk_launch) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         num_lat_q    <= '0;
         settle_lat_q <= '0;
         gap_lat_q    <= '0;
         launch_cnt_q <= '0;
         pg_en_q      <= 1'b0;
         pg_tog_q     <= 1'b0;
         cap_strobe_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         num_lat_q    <= num_lat_d;
         settle_lat_q <= settle_lat_d;
         gap_lat_q    <= gap_lat_d;
         launch_cnt_q <= launch_cnt_d;
         pg_en_q      <= pg_en_d;
         pg_tog_q     <= pg_tog_d;
         cap_strobe_q <= cap_strobe_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign pg_en      = pg_en_q;
   assign pg_tog     = pg_tog_q;
   assign cap_strobe = cap_strobe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign launch_cnt = launch_cnt_q;

endmodule

// File: tb/tb_tdc_launch_seq.sv
// -----------------------------------------------------------------------------
// tb_tdc_launch_seq
//
// Self-checking bench for tdc_launch_seq (CNT_W=8, TMR_W=8).
//
// The reference model does not step through states. It describes a burst by
// the cycle offset k since the accepted start (k=1 is the first launch) and
// the latched num/settle/gap values. From those it works out, with plain
// arithmetic, which cycles carry a launch, a strobe or done, and how many
// strobes and launches have occurred by cycle k. Directed scenarios with
// hand-written cycle lists fix the model's timing. Randomised traffic then
// exercises start, abort and rst.
// -----------------------------------------------------------------------------
module tb_tdc_launch_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] num_launch = '0;
   logic [7:0] settle = '0;
   logic [7:0] gap = '0;
   logic       pg_en, pg_tog, cap_strobe, busy, done;
   logic [7:0] launch_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tdc_launch_seq #(.CNT_W(8), .TMR_W(8)) dut (
      .clk_launch (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .num_launch (num_launch),
      .settle     (settle),
      .gap        (gap),
      .pg_en      (pg_en),
      .pg_tog     (pg_tog),
      .cap_strobe (cap_strobe),
      .busy       (busy),
      .done       (done),
      .launch_cnt (launch_cnt)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   bit m_valid = 1'b0;
   bit m_burst = 1'b0;
   bit m_cont  = 1'b0;
   int m_k, m_n, m_s, m_g;
   int m_tog0, m_tog_idle, m_cnt_idle;

   always @(negedge clk) begin : model
      int p, launches, strobes, done_k;
      int e_en, e_tog, e_cap, e_busy, e_done, e_cnt;
      e_en = 0; e_tog = m_tog_idle; e_cap = 0; e_busy = 0; e_done = 0;
      e_cnt = m_cnt_idle; done_k = 0;
      if (m_burst) begin
         p = 2 + m_s + m_g;
         if (!m_cont && m_n == 0) begin
            done_k = 1;
            e_done = 1;
            e_tog  = m_tog0;
            e_cnt  = 0;
         end else begin
            done_k   = (m_n - 1) * p + 3 + m_s;
            launches = (m_k - 1) / p + 1;
            if (!m_cont && launches > m_n) launches = m_n;
            strobes  = (m_k < 3 + m_s) ? 0 : (m_k - 3 - m_s) / p + 1;
            if (!m_cont && strobes > m_n) strobes = m_n;
            if (strobes > 255) strobes = 255;
            e_en   = (((m_k - 1) % p) == 0 && (m_cont || (m_k - 1) / p < m_n)) ? 1 : 0;
            e_cap  = (m_k >= 2 + m_s && ((m_k - 2 - m_s) % p) == 0 &&
                      (m_cont || (m_k - 2 - m_s) / p < m_n)) ? 1 : 0;
            e_busy = (m_cont || m_k < done_k) ? 1 : 0;
            e_done = (!m_cont && m_k == done_k) ? 1 : 0;
            e_tog  = m_tog0 ^ (launches & 1);
            e_cnt  = strobes;
         end
      end
      if (m_valid) begin
         chk("model.pg_en", int'(pg_en), e_en);
         chk("model.pg_tog", int'(pg_tog), e_tog);
         chk("model.cap_strobe", int'(cap_strobe), e_cap);
         chk("model.busy", int'(busy), e_busy);
         chk("model.done", int'(done), e_done);
         chk("model.launch_cnt", int'(launch_cnt), e_cnt);
      end
      // advance to the next cycle using the inputs held during this one
      if (rst) begin
         m_valid = 1'b1;
         m_burst = 1'b0;
         m_tog_idle = 0;
         m_cnt_idle = 0;
      end else if (m_valid) begin
         if (m_burst && (abort || (!m_cont && m_k == done_k))) begin
            m_burst    = 1'b0;
            m_tog_idle = e_tog;
            m_cnt_idle = e_cnt;
         end else if (m_burst) begin
            m_k++;
         end else if (start && !abort) begin
            m_burst = 1'b1;
            m_k     = 1;
            m_n     = int'(num_launch);
            m_s     = int'(settle);
            m_g     = int'(gap);
            m_tog0  = m_tog_idle;
`ifdef TDC_LSEQ_CONT_EN
            m_cont  = (num_launch == 8'd0);
`else
            m_cont  = 1'b0;
`endif
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Directed burst with literal cycle lists. Bit k of en_m/cap_m marks cycle
   // k after the accepted start. A start with num_launch=1 is pulsed in
   // cycle restart_k and must be ignored.
   task automatic run_dir(input string name, input int n, input int s, input int g,
                          input logic [31:0] en_m, input logic [31:0] cap_m,
                          input int done_k, input int fin_cnt, input int ncyc,
                          input int restart_k);
      int tog;
      tog = 0;
      do_reset();
      num_launch = 8'(n); settle = 8'(s); gap = 8'(g); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      // changing the inputs mid-burst must not disturb the latched values
      num_launch = 8'($urandom); settle = 8'($urandom); gap = 8'($urandom);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (en_m[k]) tog ^= 1;
         chk({name, ".pg_en"}, int'(pg_en), int'(en_m[k]));
         chk({name, ".cap_strobe"}, int'(cap_strobe), int'(cap_m[k]));
         chk({name, ".done"}, int'(done), (k == done_k) ? 1 : 0);
         chk({name, ".busy"}, int'(busy), (k < done_k) ? 1 : 0);
         chk({name, ".pg_tog"}, int'(pg_tog), tog);
         if (k == done_k) chk({name, ".launch_cnt"}, int'(launch_cnt), fin_cnt);
         if (k + 1 == restart_k) begin
            @(posedge clk); #1;
            start = 1'b1; num_launch = 8'd1;
         end
         if (k == restart_k) begin
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.pg_en", int'(pg_en), 0);
      chk("reset.pg_tog", int'(pg_tog), 0);
      chk("reset.cap_strobe", int'(cap_strobe), 0);
      chk("reset.busy", int'(busy), 0);
      chk("reset.done", int'(done), 0);
      chk("reset.launch_cnt", int'(launch_cnt), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_dir("n3s2g1", 3, 2, 1, (32'd1 << 1) | (32'd1 << 6) | (32'd1 << 11),
              (32'd1 << 4) | (32'd1 << 9) | (32'd1 << 14), 15, 3, 16, -1);
      run_dir("n1s0g0", 1, 0, 0, (32'd1 << 1), (32'd1 << 2), 3, 1, 4, -1);
      run_dir("n2s0g0", 2, 0, 0, (32'd1 << 1) | (32'd1 << 3),
              (32'd1 << 2) | (32'd1 << 4), 5, 2, 6, -1);
      run_dir("n5s3_restart", 5, 3, 0,
              (32'd1 << 1) | (32'd1 << 6) | (32'd1 << 11) | (32'd1 << 16) | (32'd1 << 21),
              (32'd1 << 5) | (32'd1 << 10) | (32'd1 << 15) | (32'd1 << 20) | (32'd1 << 25),
              26, 5, 27, 4);

      // abort during SETTLE of the 2nd launch (period 5, launch 2 at k=6)
      do_reset();
      num_launch = 8'd4; settle = 8'd2; gap = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1 abort = 1'b1;
      @(negedge clk);
      chk("abort.busy_before", int'(busy), 1);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort.busy", int'(busy), 0);
      chk("abort.pg_en", int'(pg_en), 0);
      chk("abort.cap_strobe", int'(cap_strobe), 0);
      chk("abort.done", int'(done), 0);
      chk("abort.launch_cnt", int'(launch_cnt), 1);
      chk("abort.pg_tog", int'(pg_tog), 0);
      @(negedge clk);
      chk("abort.cap_late", int'(cap_strobe), 0);
      chk("abort.done_late", int'(done), 0);

      // rst asserted mid-GAP (settle=1, gap=4: k=4..7 are GAP)
      do_reset();
      num_launch = 8'd3; settle = 8'd1; gap = 8'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rstgap.tog_before", int'(pg_tog), 1);
      chk("rstgap.cnt_before", int'(launch_cnt), 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstgap.pg_tog", int'(pg_tog), 0);
      chk("rstgap.launch_cnt", int'(launch_cnt), 0);
      chk("rstgap.busy", int'(busy), 0);
      chk("rstgap.done", int'(done), 0);

`ifdef TDC_LSEQ_CONT_EN
      // continuous mode: settle=1, gap=0 gives a strobe every 3 cycles
      do_reset();
      num_launch = 8'd0; settle = 8'd1; gap = 8'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         chk("cont.pg_en", int'(pg_en), (k % 3 == 1) ? 1 : 0);
         chk("cont.cap_strobe", int'(cap_strobe), (k % 3 == 0) ? 1 : 0);
         chk("cont.busy", int'(busy), 1);
         chk("cont.done", int'(done), 0);
      end
      repeat (770) @(negedge clk);
      chk("cont.saturated", int'(launch_cnt), 255);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("cont.abort_busy", int'(busy), 0);
      chk("cont.abort_cnt", int'(launch_cnt), 255);
`else
      run_dir("zero", 0, 0, 0, 32'd0, 32'd0, 1, 0, 3, -1);
`endif

      // randomised traffic against the model
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         start      = ($urandom_range(5) == 0);
         abort      = ($urandom_range(39) == 0);
         rst        = ($urandom_range(299) == 0);
         num_launch = ($urandom_range(30) == 0) ? 8'($urandom) : 8'($urandom_range(4));
         if (num_launch > 8'd6) num_launch = 8'd6;
         settle     = ($urandom_range(60) == 0) ? 8'd255 : 8'($urandom_range(3));
         gap        = ($urandom_range(60) == 0) ? 8'd255 : 8'($urandom_range(3));
      end
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
